clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Runtime-programmable clock-divider controller. It generates a one-cycle `clk_flag` tick and a near-50%-duty `clk_out` at sys_clk/N. It sequences start/stop and applies ratio changes only at period boundaries, so consumers never see a truncated or stretched period. It replaces fixed-ratio dividers (e.g. divide-by-five) wherever firmware or upstream logic must retune the ratio live.

Parameters:
- DIV_W, 8: width of the divide ratio and the internal counter.
- DIV_DEFAULT, 5: ratio loaded at reset. Must satisfy 2 <= DIV_DEFAULT <= 2^DIV_W-1.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- run_en  in  1  level; 1 requests running, 0 requests stop at the next boundary.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  DIV_W  offered ratio N.
- cfg_ready  out  1  controller can accept a ratio.
- cfg_err  out  1  one-cycle pulse: the accepted cfg_div was < 2 and was dropped.
- busy  out  1  state != IDLE.
- cur_div  out  DIV_W  ratio currently in effect.
- clk_flag  out  1  one-cycle tick, once per period.
- clk_out  out  1  divided clock.

Behaviour:
- Reset (async assert): state=IDLE, cnt=0, cur_div=DIV_DEFAULT, pend_vld=0, clk_flag=0, clk_out=0, cfg_err=0, busy=0, cfg_ready=1. Outputs drop immediately on assertion, including mid-period; no period completion.
- Registered outputs: all outputs are registered, with no combinational path from inputs to outputs.
- Handshake: a transfer occurs when cfg_valid & cfg_ready on an edge. cfg_ready = !pend_vld.
- States are IDLE, RUN and STOP.
- IDLE:
  - cnt=0, clk_out=0, clk_flag=0.
  - An accepted cfg with cfg_div>=2 sets cur_div on the same edge.
  - run_en=1 sampled at edge k: go to RUN, with cnt=0 after edge k.
- RUN:
  - cnt counts 0..cur_div-1 and wraps to 0.
  - clk_flag=1 exactly in the cycle where cnt==cur_div-1.
  - clk_out=1 while cnt < ceil(cur_div/2). For N=5 this gives 3 high, 2 low; for N=4, 2 high, 2 low.
  - The first clk_flag follows edge k+N-1. After that, the period is exactly N cycles.
  - run_en=0: go to STOP. Counting continues unchanged.
- STOP:
  - Counting continues. At the boundary edge (cnt==cur_div-1) the block goes to IDLE.
  - The final clk_flag is emitted. There are no partial periods.
  - run_en=1 seen in STOP: return to RUN with no gap and no counter disturbance.
- Config while busy:
  - An accepted cfg (>=2) is stored in pend_div with pend_vld=1, which drops cfg_ready.
  - At the next boundary edge (cnt==cur_div-1 with pend_vld=1): cur_div<=pend_div, pend_vld<=0, cnt<=0. The new period starts on the following cycle.
  - If acceptance and boundary coincide on the same edge, the value is applied at the following boundary, never the current one.
  - A pending value at the STOP→IDLE boundary is applied on that edge.
- Invalid ratio: an accepted cfg_div of 0 or 1 pulses cfg_err for one cycle (the cycle after the accept edge). There is no state change, and pend_vld is not set.
- Width rule: cnt is DIV_W bits. cur_div-1 and ceil(N/2) are computed in DIV_W+1 bits, so there is no overflow at N=2^DIV_W-1.

Decomposition:
- Shared include/package `clk_div_pkg`:
  - state encodings ST_IDLE/ST_RUN/ST_STOP;
  - DIV_MIN=2.
- One sub-module, `clk_div_core`:
  - holds the counter, the boundary detect, clk_flag and clk_out;
  - inputs are cnt_en, cnt_clr and div;
  - outputs are boundary and the registered flag/clock.
- clk_div_ctrl holds the FSM, the config handshake and the pending register.

Test Plan:
1. Default bring-up: release reset, run_en=1 → clk_flag every 5 cycles; clk_out pattern 1,1,1,0,0; cur_div=5; cfg_ready=1.
2. Live retune: while running N=5, write cfg_div=8 mid-period → cfg_ready=0 until the boundary. The current period completes at 5 cycles, subsequent periods are 8 cycles with clk_out 4 high/4 low, and cfg_ready returns to 1.
3. Boundary collision plus back-pressure: accept cfg_div=3 on the cnt==N-1 edge → applied only at the next boundary. A second cfg_valid while pend_vld=1 sees cfg_ready=0 and is not consumed.
4. Invalid ratios: cfg_div=1, then 0, in IDLE and in RUN → one-cycle cfg_err each; cur_div and the period are unchanged.
5. Stop/restart: drop run_en at cnt=1 (N=5) → 3 more cycles, final clk_flag, then IDLE with busy=0. Reassert run_en during STOP instead → period train continues seamlessly.
6. Reset mid-operation: assert sys_rst_n=0 at cnt=2 with pend_vld=1 → all outputs 0 immediately; after release cur_div=5, pend_vld=0, IDLE.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encodings and limits for the clock divider
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter with registered tick and divided clock
module clk_div_core #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    input  logic [DIV_W-1:0] div,
    output logic             boundary,
    output logic             clk_flag,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_flag_q, clk_flag_d;
    logic             clk_out_q, clk_out_d;
    logic [DIV_W:0]   div_last;
    logic [DIV_W:0]   div_half;

    // cnt_en and div describe the coming cycle, so flag/out are registered from next-state values
    assign div_last = {1'b0, div} - 1'b1;
    assign div_half = ({1'b0, div} + 1'b1) >> 1;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_clr || !cnt_en || clk_flag_q) begin
            cnt_d = '0;
        end
        clk_flag_d = cnt_en && ({1'b0, cnt_d} == div_last);
        clk_out_d  = cnt_en && ({1'b0, cnt_d} <  div_half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            clk_flag_q <= 1'b0;
            clk_out_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clk_flag_q <= clk_flag_d;
            clk_out_q  <= clk_out_d;
        end
    end

    // The tick marks exactly the cnt == div-1 cycle, which is the period boundary
    assign boundary = clk_flag_q;
    assign clk_flag = clk_flag_q;
    assign clk_out  = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop sequencing and boundary-aligned ratio updates
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_flag,
    output logic             clk_out
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_q, busy_d;
    logic             boundary;
    logic             accept;
    logic             ratio_ok;

    assign accept   = cfg_valid && !pend_vld_q;
    assign ratio_ok = cfg_div >= DIV_W'(DIV_MIN);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run_en) state_d = ST_RUN;
            ST_RUN:  if (!run_en) state_d = ST_STOP;
            ST_STOP: begin
                if (run_en) begin
                    state_d = ST_RUN;
                end else if (boundary) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = accept && !ratio_ok;
        busy_d     = (state_d != ST_IDLE);
        if (state_q == ST_IDLE) begin
            if (accept && ratio_ok) begin
                cur_div_d = cfg_div;
            end
        end else begin
            // accept needs !pend_vld_q, so a same-edge accept always waits one more period
            if (boundary && pend_vld_q) begin
                cur_div_d  = pend_div_q;
                pend_vld_d = 1'b0;
            end
            if (accept && ratio_ok) begin
                pend_div_d = cfg_div;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_div_q  <= DIV_W'(DIV_DEFAULT);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
        end
    end

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .cnt_en   (state_d != ST_IDLE),
        .cnt_clr  (state_q == ST_IDLE),
        .div      (cur_div_d),
        .boundary (boundary),
        .clk_flag (clk_flag),
        .clk_out  (clk_out)
    );

    assign cfg_ready = !pend_vld_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;
    assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed scoreboard bench for clk_div_ctrl
module tb_clk_div_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       run_en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       busy;
    logic [7:0] cur_div;
    logic       clk_flag;
    logic       clk_out;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] sb[$];

    clk_div_ctrl #(
        .DIV_W       (8),
        .DIV_DEFAULT (5)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .cur_div   (cur_div),
        .clk_flag  (clk_flag),
        .clk_out   (clk_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic push_cycles(input int n, input int len);
        for (int i = 0; i < len; i++) begin
            sb.push_back({(i == n - 1), (i < (n + 1) / 2)});
        end
    endtask

    task automatic push_idle(input int k);
        for (int i = 0; i < k; i++) sb.push_back(2'b00);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic step_chk();
        logic [1:0] e;
        step();
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("clk_flag", clk_flag, e[1]);
            chk("clk_out", clk_out, e[0]);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        run_en    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        repeat (2) step();
        chk("rst_flag", clk_flag, 0);
        chk("rst_out", clk_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_err", cfg_err, 0);
        chk("rst_div", cur_div, 5);
        sys_rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_out", clk_out, 0);

        // default bring-up at N=5
        run_en = 1'b1;
        repeat (3) push_cycles(5, 5);
        step_chk();
        chk("run_busy", busy, 1);
        chk("run_div", cur_div, 5);
        chk("run_ready", cfg_ready, 1);
        repeat (14) step_chk();

        // live retune to 8 mid-period
        push_cycles(5, 5);
        repeat (2) push_cycles(8, 8);
        repeat (2) step_chk();
        cfg_valid = 1'b1;
        cfg_div   = 8'd8;
        step_chk();
        cfg_valid = 1'b0;
        chk("retune_ready_lo", cfg_ready, 0);
        chk("retune_div_old", cur_div, 5);
        repeat (2) step_chk();
        chk("retune_ready_bnd", cfg_ready, 0);
        step_chk();
        chk("retune_ready_hi", cfg_ready, 1);
        chk("retune_div_new", cur_div, 8);
        repeat (15) step_chk();

        // accept on the boundary edge, then back-pressure a second offer
        repeat (2) push_cycles(8, 8);
        repeat (2) push_cycles(3, 3);
        repeat (8) step_chk();
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        step_chk();
        chk("coll_ready_lo", cfg_ready, 0);
        chk("coll_div_kept", cur_div, 8);
        cfg_div = 8'd6;
        repeat (7) step_chk();
        cfg_valid = 1'b0;
        step_chk();
        chk("coll_div_new", cur_div, 3);
        chk("coll_ready_hi", cfg_ready, 1);
        repeat (5) step_chk();
        chk("coll_second_dropped", cur_div, 3);

        // invalid ratios while running
        repeat (2) push_cycles(3, 3);
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        step_chk();
        chk("run_err_1", cfg_err, 1);
        cfg_div = 8'd0;
        step_chk();
        chk("run_err_0", cfg_err, 1);
        cfg_valid = 1'b0;
        step_chk();
        chk("run_err_clear", cfg_err, 0);
        chk("run_err_div", cur_div, 3);
        chk("run_err_ready", cfg_ready, 1);
        repeat (3) step_chk();

        // retune to 5 on a boundary, then stop at cnt=1
        push_cycles(3, 3);
        push_cycles(5, 5);
        push_idle(2);
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        step_chk();
        cfg_valid = 1'b0;
        chk("stop_pend", cfg_ready, 0);
        repeat (2) step_chk();
        step_chk();
        chk("stop_div", cur_div, 5);
        step_chk();
        run_en = 1'b0;
        step_chk();
        chk("stop_busy", busy, 1);
        repeat (2) step_chk();
        step_chk();
        chk("stop_idle", busy, 0);
        step_chk();

        // invalid and valid ratios in IDLE
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        step();
        chk("idle_err_0", cfg_err, 1);
        chk("idle_err_div", cur_div, 5);
        cfg_div = 8'd1;
        step();
        chk("idle_err_1", cfg_err, 1);
        cfg_div = 8'd4;
        step();
        cfg_valid = 1'b0;
        chk("idle_err_clear", cfg_err, 0);
        chk("idle_div_direct", cur_div, 4);
        chk("idle_ready", cfg_ready, 1);
        chk("idle_busy2", busy, 0);

        // reassert run_en during STOP: seamless period train
        run_en = 1'b1;
        repeat (3) push_cycles(4, 4);
        repeat (2) step_chk();
        run_en = 1'b0;
        step_chk();
        run_en = 1'b1;
        step_chk();
        chk("resume_busy", busy, 1);
        repeat (8) step_chk();

        // async reset mid-period with a pending ratio
        push_cycles(4, 3);
        step_chk();
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        step_chk();
        cfg_valid = 1'b0;
        chk("mid_pend", cfg_ready, 0);
        step_chk();
        #2;
        sys_rst_n = 1'b0;
        run_en    = 1'b0;
        #1;
        chk("arst_flag", clk_flag, 0);
        chk("arst_out", clk_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_div", cur_div, 5);
        repeat (2) step();
        sys_rst_n = 1'b1;
        step();
        chk("post_busy", busy, 0);
        chk("post_div", cur_div, 5);
        chk("post_ready", cfg_ready, 1);
        run_en = 1'b1;
        repeat (2) push_cycles(5, 5);
        repeat (10) step_chk();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
